// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq : multi-cycle ALU with a start/done handshake.
//
// One operation is accepted per handshake. Its operands are latched on the
// accept edge. The result and flags are registered on the done edge.
// Shifts of any distance run one bit per cycle. Right shifts can round to
// nearest by adding back the last bit shifted out.
//
// Opcodes:
//   1 pass   C = A
//   2 add    C = A + B, cy = carry-out
//   3 sub    C = B - A, cy = borrow (B < A)
//   4 lshift C = B << shamt
//   5 rshift C = (B >> shamt) + last bit shifted out
//   0,6,7    NOP: C/z/cy hold, done still pulses
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; aborts any operation in flight
//   start      request; accepted on a clk edge while busy = 0
//   operation  opcode, sampled at accept
//   A, B       operands (WIDTH), sampled at accept
//   shamt      shift distance (SHAMT_W), sampled at accept
//   busy       high from the accept edge until the done edge
//   done       one-cycle pulse; C/z/cy are valid from this cycle on
//   C          registered result, held until the next done
//   z          registered C == 0
//   cy         registered carry/borrow; 0 for all other operations
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         operation,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   C,
    output logic               z,
    output logic               cy
);

    localparam logic [2:0] OP_PASS = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_LSH  = 3'd4;
    localparam logic [2:0] OP_RSH  = 3'd5;

    localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
    localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   W_ZERO   = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t             state_r;
    logic [2:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    // Holds latched B; doubles as the shift register during SHIFT.
    logic [WIDTH-1:0]   work_r;
    logic [SHAMT_W-1:0] cnt_r;
    logic               g_r;

    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH-1:0]   shift_res_s;
    logic               exec_upd_s;
    logic [WIDTH-1:0]   exec_c_s;
    logic               exec_cy_s;

    // Zero detect used for the z flag.
    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return (v == W_ZERO);
    endfunction

    // Arithmetic results for EXEC and the rounded shift result for SHIFT.
    always_comb begin
        sum_s       = {1'b0, a_r} + {1'b0, work_r};
        // The extra top bit of the widened difference is the borrow.
        diff_s      = {1'b0, work_r} - {1'b0, a_r};
        // g_r is only ever set by right shifts, so lshift adds nothing here.
        // The shifted value is below 2^(WIDTH-1) whenever g_r can be 1,
        // so the sum cannot wrap.
        shift_res_s = work_r + {{(WIDTH-1){1'b0}}, g_r};
        exec_upd_s  = 1'b0;
        exec_c_s    = C;
        exec_cy_s   = cy;
        case (op_r)
            OP_PASS: begin
                exec_upd_s = 1'b1;
                exec_c_s   = a_r;
                exec_cy_s  = 1'b0;
            end
            OP_ADD: begin
                exec_upd_s = 1'b1;
                exec_c_s   = sum_s[WIDTH-1:0];
                exec_cy_s  = sum_s[WIDTH];
            end
            OP_SUB: begin
                exec_upd_s = 1'b1;
                exec_c_s   = diff_s[WIDTH-1:0];
                exec_cy_s  = diff_s[WIDTH];
            end
            default: begin
                exec_upd_s = 1'b0;
                exec_c_s   = C;
                exec_cy_s  = cy;
            end
        endcase
    end

    // Control FSM with registered result, flags and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            op_r    <= 3'd0;
            a_r     <= W_ZERO;
            work_r  <= W_ZERO;
            cnt_r   <= CNT_ZERO;
            g_r     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            C       <= W_ZERO;
            z       <= 1'b0;
            cy      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r   <= operation;
                        a_r    <= A;
                        work_r <= B;
                        cnt_r  <= shamt;
                        g_r    <= 1'b0;
                        busy   <= 1'b1;
                        if ((operation == OP_LSH) || (operation == OP_RSH)) begin
                            state_r <= SHIFT;
                        end else begin
                            state_r <= EXEC;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    if (exec_upd_s) begin
                        C  <= exec_c_s;
                        z  <= is_zero(exec_c_s);
                        cy <= exec_cy_s;
                    end else begin
                        C  <= C;
                        z  <= z;
                        cy <= cy;
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                SHIFT: begin
                    if (cnt_r != CNT_ZERO) begin
                        if (op_r == OP_RSH) begin
                            work_r <= {1'b0, work_r[WIDTH-1:1]};
                            g_r    <= work_r[0];
                        end else begin
                            work_r <= {work_r[WIDTH-2:0], 1'b0};
                            g_r    <= 1'b0;
                        end
                        cnt_r <= cnt_r - CNT_ONE;
                    end else begin
                        C       <= shift_res_s;
                        z       <= is_zero(shift_res_s);
                        cy      <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver pushes hand-computed expectations,
// and a monitor pops and checks one of them on every done pulse.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  operation = 3'd0;
    logic [15:0] A = 16'h0000;
    logic [15:0] B = 16'h0000;
    logic [3:0]  shamt = 4'd0;
    logic        busy;
    logic        done;
    logic [15:0] C;
    logic        z;
    logic        cy;

    alu_seq #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .operation(operation),
        .A(A), .B(B), .shamt(shamt),
        .busy(busy), .done(done), .C(C), .z(z), .cy(cy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] c;
        logic        zf;
        logic        cf;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_C"},   int'(C), int'(e.c));
                chk({e.name, "_z"},   int'(z), int'(e.zf));
                chk({e.name, "_cy"},  int'(cy), int'(e.cf));
                chk({e.name, "_lat"}, cyc - e.acc, e.lat);
                chk({e.name, "_busy_at_done"}, int'(busy), 0);
            end
        end
    end

    // Drive one request from a negedge; it is accepted on the next posedge.
    task automatic issue(input string name, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] sh,
                         input logic [15:0] ec, input logic ez, input logic ecy,
                         input int elat);
        exp_t e;
        chk({name, "_idle_before"}, int'(busy), 0);
        operation = op; A = a; B = b; shamt = sh; start = 1'b1;
        @(posedge clk);
        #1;
        e.c = ec; e.zf = ez; e.cf = ecy; e.lat = elat; e.acc = cyc; e.name = name;
        sb.push_back(e);
        start = 1'b0;
        // Scramble inputs: the latched copy must be used.
        A = ~a; B = ~b; shamt = ~sh; operation = 3'd2;
    endtask

    // Wait (bounded) for a done pulse; returns at the negedge where done is high.
    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk({name, "_done_timeout"}, 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_C", int'(C), 0);
        chk("rst_z", int'(z), 0);
        chk("rst_cy", int'(cy), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue("add_carry", 3'd2, 16'hFFFF, 16'h0002, 4'd0, 16'h0001, 1'b0, 1'b1, 1);
        // busy for exactly one cycle: high now, done at the next negedge
        @(negedge clk);
        chk("add_busy_mid", int'(busy), 1);
        wait_done("add_carry");
        issue("sub_equal", 3'd3, 16'h0005, 16'h0005, 4'd0, 16'h0000, 1'b1, 1'b0, 1);
        wait_done("sub_equal");
        issue("sub_borrow", 3'd3, 16'h0006, 16'h0005, 4'd0, 16'hFFFF, 1'b0, 1'b1, 1);
        wait_done("sub_borrow");
        issue("rsh_6_2", 3'd5, 16'h0000, 16'h0006, 4'd2, 16'h0002, 1'b0, 1'b0, 3);
        wait_done("rsh_6_2");
        issue("rsh_ffff_15", 3'd5, 16'h0000, 16'hFFFF, 4'd15, 16'h0002, 1'b0, 1'b0, 16);
        wait_done("rsh_ffff_15");
        issue("rsh_sh0", 3'd5, 16'h0000, 16'hABCD, 4'd0, 16'hABCD, 1'b0, 1'b0, 1);
        wait_done("rsh_sh0");
        issue("lsh_8001_1", 3'd4, 16'h0000, 16'h8001, 4'd1, 16'h0002, 1'b0, 1'b0, 2);
        // start while busy must be ignored (an extra done would be flagged)
        @(negedge clk);
        operation = 3'd1; A = 16'hAAAA; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("lsh_8001_1");
        // back-to-back: start asserted in the done cycle
        issue("pass_b2b", 3'd1, 16'h1357, 16'h0000, 4'd0, 16'h1357, 1'b0, 1'b0, 1);
        wait_done("pass_b2b");
        issue("add_1234", 3'd2, 16'h1200, 16'h0034, 4'd0, 16'h1234, 1'b0, 1'b0, 1);
        wait_done("add_1234");
        issue("nop6", 3'd6, 16'hFFFF, 16'hFFFF, 4'd0, 16'h1234, 1'b0, 1'b0, 1);
        wait_done("nop6");
        issue("add_ffff_ffff", 3'd2, 16'hFFFF, 16'hFFFF, 4'd0, 16'hFFFE, 1'b0, 1'b1, 1);
        wait_done("add_ffff_ffff");
        issue("nop7", 3'd7, 16'h0000, 16'h0000, 4'd0, 16'hFFFE, 1'b0, 1'b1, 1);
        wait_done("nop7");

        // Abort a shift mid-flight: no expectation is pushed for it.
        operation = 3'd5; B = 16'h1234; shamt = 4'd10; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_C", int'(C), 0);
        chk("abort_z", int'(z), 0);
        chk("abort_cy", int'(cy), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("abort_still_idle", int'(busy), 0);

        issue("pass_zero", 3'd1, 16'h0000, 16'h5555, 4'd0, 16'h0000, 1'b1, 1'b0, 1);
        wait_done("pass_zero");
        issue("nop0", 3'd0, 16'h7777, 16'h7777, 4'd3, 16'h0000, 1'b1, 1'b0, 1);
        wait_done("nop0");
        issue("lsh_1_15", 3'd4, 16'h0000, 16'h0001, 4'd15, 16'h8000, 1'b0, 1'b0, 16);
        wait_done("lsh_1_15");
        issue("rsh_round_dn", 3'd5, 16'h0000, 16'h0009, 4'd2, 16'h0002, 1'b0, 1'b0, 3);
        wait_done("rsh_round_dn");
        issue("lsh_out_zero", 3'd4, 16'h0000, 16'h8000, 4'd1, 16'h0000, 1'b1, 1'b0, 2);
        wait_done("lsh_out_zero");

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the datapath ALU.
- Accepts one operation per start/done handshake and registers its result and flags.
- Performs arbitrary-distance shifts iteratively, one bit per cycle, with optional round-to-nearest on right shifts.
- Sits between the register file/bus and the control unit; the control unit holds its FSM while busy is high.

Parameters:
WIDTH, 16, datapath width of A, B, C
SHAMT_W, 4, width of shift-amount port; legal shift 0..2^SHAMT_W-1, and 2^SHAMT_W-1 must be <= WIDTH-1

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request; accepted on a clk edge when busy=0
operation  input  3  opcode, sampled at accept
A  input  WIDTH  operand A, sampled at accept
B  input  WIDTH  operand B, sampled at accept
shamt  input  SHAMT_W  shift distance, sampled at accept (shift ops only)
busy  output  1  high from accept edge until done edge
done  output  1  one-cycle pulse; C/z/cy valid from this cycle on
C  output  WIDTH  registered result, held until next done
z  output  1  registered: C==0, updated with C
cy  output  1  registered carry (add) / borrow (sub), else 0

Behaviour:
- Reset (async, any state, including mid-operation):
  - C=0, z=0, cy=0, busy=0, done=0, FSM=IDLE.
  - Any operation in flight is aborted; no done is issued for it.
- Opcodes (all other results are modulo 2^WIDTH):
  - 1 pass: C=A.
  - 2 add: C=A+B; cy=carry-out.
  - 3 sub: C=B-A; cy=1 iff B<A (unsigned).
  - 4 lshift: C=B<<shamt; zero fill.
  - 5 rshift: C=(B>>shamt)+g, where g=last bit shifted out (g=0 when shamt=0); logical, zero fill. shamt=2 gives the legacy divide-by-4 rounding behaviour.
  - 0,6,7: C, z, cy hold their values; done still pulses (acts as NOP).
- FSM states: IDLE, EXEC, SHIFT.
  - IDLE:
    - start=1 -> latch operands, busy=1.
    - op 4/5 -> SHIFT with cnt=shamt, work=B, g=0.
    - any other op -> EXEC.
  - EXEC: compute, register C/z/cy, done=1, busy=0 -> IDLE.
  - SHIFT:
    - cnt!=0: shift work by 1, g=bit shifted out (rshift only), cnt-=1.
    - cnt==0: C=work(+g for rshift), z, cy=0, done=1, busy=0 -> IDLE.
- Latency: accept at edge k gives done high after edge k+1 for non-shift ops, and after edge k+1+shamt for shifts (shamt=0 gives latency 1).
- Handshake:
  - start while busy=1 is ignored, not queued.
  - busy and done change on the same edge. A start asserted in the done cycle is accepted on the next edge (back-to-back throughput, no bubble beyond the done cycle).
  - done never asserts without a prior accept.
- Rounding overflow:
  - rshift rounding cannot overflow, since the shifted value is at most 2^(WIDTH-1)-1 when shamt>=1.
  - cy is always 0 for shifts.
- Operand stability: inputs may change freely after accept; the latched copy is used.
- z and cy update only on the done edge and are otherwise stable.

Test Plan:
- Reset, then add A=0xFFFF, B=0x0002 -> done after 1 cycle, C=0x0001, cy=1, z=0; busy high exactly 1 cycle.
- sub A=0x0005, B=0x0005 -> C=0x0000, z=1, cy=0. Then sub A=0x0006, B=0x0005 -> C=0xFFFF, cy=1, z=0.
- rshift B=0x0006, shamt=2 -> done 3 cycles after accept, C=0x0002. Then B=0xFFFF, shamt=15 -> 16 cycles, C=0x0002. Then shamt=0 -> 1 cycle, C=B.
- lshift B=0x8001, shamt=1 -> C=0x0002. During busy, pulse start with op=pass -> ignored, no extra done. Then op=pass asserted in the done cycle -> accepted next edge, done 1 cycle later with C=A.
- Assert rst mid-shift (shamt=10, cnt=5) -> C=0, z=0, cy=0, busy=0 immediately (async). No done follows; the next start works normally.
- Opcode 6 after add result 0x1234 -> done pulses, C stays 0x1234, z and cy unchanged.
